// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Contents: op_e (HI/LO operation codes), state_e (sequencer FSM states),
// ITER_COUNT (number of shift iterations), and a 32-bit magnitude helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_e;

  localparam int unsigned ITER_COUNT = 32;
  localparam logic [4:0]  CNT_LAST   = 5'(ITER_COUNT - 1);

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: 64-bit accumulator plus operand register, advanced
// one bit per step.
//   multiply: acc = {partial, multiplier}; shift-add of the operand.
//   divide  : acc = {remainder, quotient}; restoring shift-subtract.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   load                load acc = {0, init_lo}, operand = opnd_in
//   step                perform one iteration
//   is_div              select divide step (only when MULDIV_DIV_EN defined)
//   init_lo, opnd_in    load values
//   acc                 current accumulator
// Build option: MULDIV_DIV_EN compiles in the divide step.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
`ifdef MULDIV_DIV_EN
  input  logic        is_div,
`endif
  input  logic [31:0] init_lo,
  input  logic [31:0] opnd_in,
  output logic [63:0] acc
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [32:0] mul_sum;
`ifdef MULDIV_DIV_EN
  logic [32:0] div_top;
  logic [32:0] div_diff;
`endif

  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
`ifdef MULDIV_DIV_EN
    // Partial remainder shifted left with the next dividend bit; bit 32 of
    // the difference is the borrow that decides restore vs. keep.
    div_top  = acc_q[63:31];
    div_diff = div_top - {1'b0, opnd_q};
`endif
    if (load) begin
      acc_d  = {32'd0, init_lo};
      opnd_d = opnd_in;
    end else if (step) begin
      acc_d = {mul_sum, acc_q[31:1]};
`ifdef MULDIV_DIV_EN
      if (is_div) begin
        if (div_diff[32]) acc_d = {div_top[31:0], acc_q[30:0], 1'b0};
        else              acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer.
//   state | meaning
//   IDLE  | accepts ops; serves MFHI/MFLO, MTHI/MTLO in one cycle
//   PREP  | loads operand magnitudes into the core, latches sign flags
//   ITER  | 32 shift iterations, counter 31 down to 0
//   FIX   | applies sign fixup, writes HI/LO at the closing edge
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   op_valid, op, rs_data, rt_data operation request and operands
//   flush                         aborts in-flight op / drops IDLE op
//   stall                         op_valid while busy
//   busy                          PREP/ITER/FIX
//   rd_data, rd_valid             MFHI/MFLO result (combinational)
//   div_by_zero                   pulse in FIX of a divide by zero
// Build option: MULDIV_DIV_EN enables DIV/DIVU; otherwise they are no-ops.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        div_by_zero
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  op_e         op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        neg_res_q, neg_res_d;
`ifdef MULDIV_DIV_EN
  logic        neg_rem_q, neg_rem_d;
  logic        op_is_div;
`endif

  op_e         op_in;
  logic        op_signed;
  logic [31:0] a_mag, b_mag;
  logic [63:0] acc;
  logic        core_load, core_step;
  logic [31:0] core_init, core_opnd;

  assign op_in     = op_e'(op);
  assign op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign a_mag     = op_signed ? abs32(a_q) : a_q;
  assign b_mag     = op_signed ? abs32(b_q) : b_q;
`ifdef MULDIV_DIV_EN
  assign op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
`endif

  muldiv_iter_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (core_load),
    .step    (core_step),
`ifdef MULDIV_DIV_EN
    .is_div  (op_is_div),
`endif
    .init_lo (core_init),
    .opnd_in (core_opnd),
    .acc     (acc)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    neg_res_d   = neg_res_q;
`ifdef MULDIV_DIV_EN
    neg_rem_d   = neg_rem_q;
`endif
    core_load   = 1'b0;
    core_step   = 1'b0;
    core_init   = '0;
    core_opnd   = '0;
    busy        = (state_q != IDLE);
    stall       = op_valid & busy;
    rd_valid    = 1'b0;
    rd_data     = '0;
    div_by_zero = 1'b0;

    case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
              // Operands are captured here; upstream may move on next cycle.
              op_d    = op_in;
              a_d     = rs_data;
              b_d     = rt_data;
              state_d = PREP;
            end
            OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
              op_d    = op_in;
              a_d     = rs_data;
              b_d     = rt_data;
              state_d = PREP;
`endif
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            OP_MFHI: begin
              // reset_n gating keeps rd_valid low while reset is held.
              rd_valid = reset_n;
              rd_data  = hi_q;
            end
            OP_MFLO: begin
              rd_valid = reset_n;
              rd_data  = lo_q;
            end
            default: ;
          endcase
        end
      end

      PREP: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          neg_res_d = op_signed & (a_q[31] ^ b_q[31]);
          core_load = 1'b1;
          core_init = b_mag;
          core_opnd = a_mag;
`ifdef MULDIV_DIV_EN
          neg_rem_d = op_signed & a_q[31];
          if (op_is_div) begin
            core_init = a_mag;
            core_opnd = b_mag;
          end
`endif
          cnt_d   = CNT_LAST;
          state_d = ITER;
        end
      end

      ITER: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          core_step = 1'b1;
          if (cnt_q == 5'd0) state_d = FIX;
          else               cnt_d   = cnt_q - 5'd1;
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          {hi_d, lo_d} = neg_res_q ? (64'd0 - acc) : acc;
`ifdef MULDIV_DIV_EN
          if (op_is_div) begin
            lo_d        = neg_res_q ? (32'd0 - acc[31:0])  : acc[31:0];
            hi_d        = neg_rem_q ? (32'd0 - acc[63:32]) : acc[63:32];
            div_by_zero = (b_q == 32'd0);
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        flush;
  logic        stall, busy, rd_valid, div_by_zero;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .stall(stall), .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // {HI,LO} produced by a completed op, from plain arithmetic.
  function automatic logic [63:0] model_result(input op_e o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  begin p = sa * sb; return p; end
      OP_MULTU: begin u = {32'd0, a} * {32'd0, b}; return u; end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      OP_DIV: begin
        if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  int          m_phase = 0;   // cycles since a long op was accepted (0 = none)
  logic [31:0] m_hi = '0, m_lo = '0, m_b = '0;
  logic [63:0] m_res = '0;
  op_e         m_op = OP_MULT;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_hi    <= '0;
      m_lo    <= '0;
    end else if (m_phase != 0) begin
      if (flush) m_phase <= 0;
      else if (m_phase == 34) begin
        m_hi    <= m_res[63:32];
        m_lo    <= m_res[31:0];
        m_phase <= 0;
      end else m_phase <= m_phase + 1;
    end else if (op_valid && !flush) begin
      case (op_e'(op))
        OP_MULT, OP_MULTU: begin
          m_res <= model_result(op_e'(op), rs_data, rt_data);
          m_op <= op_e'(op); m_b <= rt_data; m_phase <= 1;
        end
        OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
          m_res <= model_result(op_e'(op), rs_data, rt_data);
          m_op <= op_e'(op); m_b <= rt_data; m_phase <= 1;
`endif
        end
        OP_MTHI: m_hi <= rs_data;
        OP_MTLO: m_lo <= rs_data;
        default: ;
      endcase
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic e_busy, e_stall, e_rdv, e_dbz, is_mf;
    logic [31:0] e_rd;
    is_mf = (op_e'(op) == OP_MFHI) || (op_e'(op) == OP_MFLO);
    if (!reset_n) begin
      e_busy = 0; e_stall = 0; e_rdv = 0; e_dbz = 0; e_rd = '0;
    end else begin
      e_busy  = (m_phase != 0);
      e_stall = op_valid & e_busy;
      e_rdv   = !e_busy && op_valid && !flush && is_mf;
      e_rd    = (op_e'(op) == OP_MFHI) ? m_hi : m_lo;
      e_dbz   = (m_phase == 34) && !flush && (m_op == OP_DIV || m_op == OP_DIVU) && (m_b == 32'd0);
    end
    chk("cmp_busy", busy, e_busy);
    chk("cmp_stall", stall, e_stall);
    chk("cmp_rd_valid", rd_valid, e_rdv);
    chk("cmp_div_by_zero", div_by_zero, e_dbz);
    if (e_rdv || !reset_n) chk("cmp_rd_data", rd_data, e_rdv ? e_rd : 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic v, input op_e o, input logic [31:0] a, input logic [31:0] b, input logic fl);
    op_valid = v; op = o; rs_data = a; rt_data = b; flush = fl;
  endtask
  task automatic settle();
    @(negedge clk); #1;
  endtask
  task automatic end_cyc();
    @(posedge clk); #1;
  endtask
  task automatic cyc(input logic v, input op_e o, input logic [31:0] a, input logic [31:0] b, input logic fl);
    set_in(v, o, a, b, fl);
    end_cyc();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, OP_MFHI, 0, 0, 0);
  endtask
  task automatic rd_lit(input string name, input op_e o, input logic [31:0] exp);
    set_in(1, o, 0, 0, 0);
    settle();
    chk({name, "_valid"}, rd_valid, 1);
    chk(name, rd_data, exp);
    end_cyc();
  endtask
  task automatic run_op(input op_e o, input logic [31:0] a, input logic [31:0] b);
    cyc(1, o, a, b, 0);
    idle(35);
    cyc(1, OP_MFHI, 0, 0, 0);
    cyc(1, OP_MFLO, 0, 0, 0);
  endtask

  typedef struct { op_e o; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset_n = 0;
    set_in(1, OP_MFHI, 0, 0, 0);
    end_cyc(); end_cyc();
    settle();
    chk("reset_busy", busy, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_stall", stall, 0);
    end_cyc();
    reset_n = 1;
    idle(1);

    cyc(1, OP_MTHI, 32'hA5A5A5A5, 0, 0);
    cyc(1, OP_MTLO, 32'h3C3C3C3C, 0, 0);
    rd_lit("mthi_readback", OP_MFHI, 32'hA5A5A5A5);
    rd_lit("mtlo_readback", OP_MFLO, 32'h3C3C3C3C);

    // MULT -3 * 7, count busy cycles from accept through cycle 36
    cnt = 0;
    set_in(1, OP_MULT, 32'hFFFFFFFD, 32'd7, 0);
    settle(); if (busy) cnt++;
    end_cyc();
    for (int i = 1; i <= 36; i++) begin
      set_in(0, OP_MFHI, 0, 0, 0);
      settle(); if (busy) cnt++;
      end_cyc();
    end
    chk("mult_busy_cycles", cnt, 34);
    rd_lit("mult_hi", OP_MFHI, 32'hFFFFFFFF);
    rd_lit("mult_lo", OP_MFLO, 32'hFFFFFFEB);

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd_lit("multu_hi", OP_MFHI, 32'hFFFFFFFE);
    rd_lit("multu_lo", OP_MFLO, 32'h00000001);

    // DIV -7 / 2
    cyc(1, OP_DIV, 32'hFFFFFFF9, 32'd2, 0);
    set_in(0, OP_MFHI, 0, 0, 0);
    settle();
`ifdef MULDIV_DIV_EN
    chk("div_busy_c1", busy, 1);
`else
    chk("div_noop_busy", busy, 0);
`endif
    end_cyc();
    idle(34);
`ifdef MULDIV_DIV_EN
    rd_lit("div_lo", OP_MFLO, 32'hFFFFFFFD);
    rd_lit("div_hi", OP_MFHI, 32'hFFFFFFFF);
`else
    rd_lit("div_noop_lo", OP_MFLO, 32'h00000001);
    rd_lit("div_noop_hi", OP_MFHI, 32'hFFFFFFFE);
`endif

    // DIVU 100 / 0 with pulse observed in cycles 33..35
    cyc(1, OP_DIVU, 32'd100, 32'd0, 0);
    idle(32);
    for (int c = 33; c <= 35; c++) begin
      set_in(0, OP_MFHI, 0, 0, 0);
      settle();
`ifdef MULDIV_DIV_EN
      chk($sformatf("dbz_cycle%0d", c), div_by_zero, (c == 34) ? 1 : 0);
`else
      chk($sformatf("dbz_off_cycle%0d", c), div_by_zero, 0);
`endif
      end_cyc();
    end
`ifdef MULDIV_DIV_EN
    rd_lit("divu0_lo", OP_MFLO, 32'hFFFFFFFF);
    rd_lit("divu0_hi", OP_MFHI, 32'd100);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    rd_lit("div_ovf_lo", OP_MFLO, 32'h80000000);
    rd_lit("div_ovf_hi", OP_MFHI, 32'h00000000);
`endif

    // MFLO held from cycle 1 after MULT 3*5
    cnt = 0;
    cyc(1, OP_MULT, 32'd3, 32'd5, 0);
    for (int i = 1; i <= 34; i++) begin
      set_in(1, OP_MFLO, 0, 0, 0);
      settle(); if (stall) cnt++;
      end_cyc();
    end
    chk("mflo_stall_cycles", cnt, 34);
    set_in(1, OP_MFLO, 0, 0, 0);
    settle();
    chk("mflo_c35_valid", rd_valid, 1);
    chk("mflo_c35_data", rd_data, 32'd15);
    end_cyc();

    // Held MTLO is accepted in the first cycle after FIX
    cyc(1, OP_MULT, 32'd2, 32'd3, 0);
    for (int i = 1; i <= 35; i++) cyc(1, OP_MTLO, 32'hDEADBEEF, 0, 0);
    rd_lit("held_mtlo", OP_MFLO, 32'hDEADBEEF);
    rd_lit("held_mult_hi", OP_MFHI, 32'd0);

    // MTHI then MULT flushed in cycle 10
    cyc(1, OP_MTHI, 32'h12345678, 0, 0);
    cyc(1, OP_MULT, 32'h00010000, 32'h00010000, 0);
    idle(9);
    cyc(0, OP_MFHI, 0, 0, 1);
    set_in(1, OP_MFHI, 0, 0, 0);
    settle();
    chk("flush_c11_busy", busy, 0);
    chk("flush_mfhi", rd_data, 32'h12345678);
    end_cyc();

    // flush together with op in IDLE drops the op
    cyc(1, OP_MTLO, 32'h0F0F0F0F, 0, 0);
    cyc(1, OP_MTLO, 32'h55555555, 0, 1);
    set_in(1, OP_MFLO, 0, 0, 1);
    settle();
    chk("flush_idle_rd_valid", rd_valid, 0);
    end_cyc();
    rd_lit("flush_idle_lo", OP_MFLO, 32'h0F0F0F0F);

    // reset in cycle 20 of a long op
`ifdef MULDIV_DIV_EN
    cyc(1, OP_DIV, 32'd1000, 32'd3, 0);
`else
    cyc(1, OP_MULT, 32'd1000, 32'd3, 0);
`endif
    idle(19);
    reset_n = 0;
    set_in(1, OP_MFHI, 0, 0, 0);
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_dbz", div_by_zero, 0);
    end_cyc();
    end_cyc();
    reset_n = 1;
    idle(20);
    rd_lit("rst_hi", OP_MFHI, 32'd0);
    rd_lit("rst_lo", OP_MFLO, 32'd0);

    // extra vectors checked through the model
    vecs[0] = '{OP_MULT,  32'h80000000, 32'h80000000};
    vecs[1] = '{OP_MULTU, 32'h12345678, 32'h9ABCDEF0};
    vecs[2] = '{OP_DIV,   32'd100,      32'hFFFFFFF9};
    vecs[3] = '{OP_DIVU,  32'hFFFFFFFF, 32'd3};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'h7FFFFFFF};
    vecs[5] = '{OP_DIV,   32'd5,        32'd0};
    foreach (vecs[i]) run_op(vecs[i].o, vecs[i].a, vecs[i].b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: op_valid  input  1  HI/LO operation presented this cycle.
REQ-004 SHALL have port: op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-005 SHALL have port: rs_data  input  32  first operand (dividend/multiplicand/MT source).
REQ-006 SHALL have port: rt_data  input  32  second operand (divisor/multiplier).
REQ-007 SHALL have port: flush  input  1  pipeline flush; aborts in-flight operation.
REQ-008 SHALL have port: stall  output  1  upstream holds op/operands while high.
REQ-009 SHALL have port: busy  output  1  iterative operation in flight.
REQ-010 SHALL have port: rd_data  output  32  HI or LO value for MFHI/MFLO.
REQ-011 SHALL have port: rd_valid  output  1  rd_data valid this cycle.
REQ-012 SHALL have port: div_by_zero  output  1  one-cycle pulse on a DIV/DIVU with rt_data == 0.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, ITER, FIX; ops are accepted only in IDLE with stall low.
REQ-014 SHALL, on MULT/MULTU/DIV/DIVU accepted in cycle 0, enter PREP in cycle 1, ITER in cycles 2-33 (32 iterations, counter 31 down to 0), and FIX in cycle 34, then write HI/LO at the end of cycle 34 and return to IDLE.
REQ-015 SHALL assert busy in PREP, ITER and FIX only.
REQ-016 SHALL, in PREP, latch operand magnitudes (signed ops) or raw values (unsigned ops), and latch the result sign flags.
REQ-017 SHALL multiply by unsigned shift-add over 32 iterations, producing a 64-bit product {HI,LO}; for signed ops, negate the 64-bit result in FIX when the operand signs differ.
REQ-018 SHALL divide by unsigned restoring division over 32 iterations: LO = quotient, HI = remainder; for signed ops, quotient sign = XOR of operand signs and remainder sign = dividend sign.
REQ-019 SHALL, for signed -2^31 / -1, produce LO=0x80000000, HI=0x00000000.
REQ-020 SHALL, for divide by zero, produce LO=0xFFFFFFFF and HI=rs_data (unsigned DIVU) or the restoring-natural value with sign fixup (DIV), and pulse div_by_zero in FIX.
REQ-021 SHALL assert stall = op_valid & busy; a held op is accepted in the first cycle after FIX.
REQ-022 SHALL serve MFHI/MFLO in IDLE combinationally: rd_data = HI/LO and rd_valid=1 in the same cycle; rd_valid=0 otherwise.
REQ-023 SHALL write MTHI/MTLO from rs_data at the edge ending the accept cycle, with no busy cycles; a following MFHI/MFLO in the next cycle returns the new value.
REQ-024 SHALL, on flush in PREP/ITER/FIX, return to IDLE at the next edge with HI/LO unchanged and no div_by_zero pulse.
REQ-025 SHALL, on flush together with op_valid in IDLE, drop the op (no HI/LO write, rd_valid=0).

Reset
REQ-026 SHALL, while reset_n=0, force state IDLE, HI=LO=0, iteration counter 0, internal operand/accumulator registers 0, and stall=busy=rd_valid=div_by_zero=0.
REQ-027 SHALL abort any in-flight operation on reset with no HI/LO update after release.

Configuration
REQ-028 SHALL compile division support only when MULDIV_DIV_EN is defined.
REQ-029 SHALL, without MULDIV_DIV_EN, treat DIV/DIVU as a no-op: accepted in one cycle, HI/LO unchanged, busy never set, div_by_zero held 0.

Structure
REQ-030 SHALL place the op encoding enum, FSM state enum, and ITER_COUNT=32 constant in shared package muldiv_pkg.
REQ-031 SHALL instantiate one sub-module, muldiv_iter_core, holding the 64-bit accumulator, operand register and the per-iteration add/subtract-shift step; the FSM, sign fixup and HI/LO registers remain in muldiv_sequencer.

Verification
REQ-032 SHALL verify: MULT rs=0xFFFFFFFD, rt=7 -> after cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly 34 cycles.
REQ-033 SHALL verify: MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 SHALL verify: DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=100, rt=0 -> div_by_zero pulse in cycle 34, LO=0xFFFFFFFF, HI=100.
REQ-035 SHALL verify: MFLO presented in cycle 1 after a MULT is accepted -> stall high cycles 1-34; rd_valid=1 with the new LO in cycle 35.
REQ-036 SHALL verify: MTHI 0x12345678 followed by MULT with flush in cycle 10 -> IDLE in cycle 11, MFHI returns 0x12345678.
REQ-037 SHALL verify: reset_n pulsed low in cycle 20 of a DIV -> all outputs 0 immediately, HI=LO=0 after release.
